// File: rtl/button_in_wb.sv
// Wishbone pushbutton input port: 2-flop sync, per-bit tick-based debounce, sticky edge capture.
// Define BTN_IRQ_EN to add the MASK register (address 2) and the level irq output.
module button_in_wb #(
    parameter int PORT_WIDTH = 1,
    parameter int Dw         = 32,
    parameter int Aw         = 2,
    parameter int PRESCALE   = 50000,
    parameter int DEB_TICKS  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PORT_WIDTH-1:0] btn_port_i,
    input  logic [Dw-1:0]         sa_dat_i,
    input  logic [Dw/8-1:0]       sa_sel_i,
    input  logic [Aw-1:0]         sa_addr_i,
    input  logic                  sa_stb_i,
    input  logic                  sa_cyc_i,
    input  logic                  sa_we_i,
    output logic [Dw-1:0]         sa_dat_o,
    output logic                  sa_ack_o,
    output logic                  sa_err_o,
    output logic                  sa_rty_o
`ifdef BTN_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam int PS_W  = $clog2(PRESCALE);
    localparam int CNT_W = $clog2(DEB_TICKS + 1);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_TICKS - 1);

    localparam logic [Aw-1:0] ADDR_DATA = Aw'(0);
    localparam logic [Aw-1:0] ADDR_EDGE = Aw'(1);
    localparam logic [Aw-1:0] ADDR_MASK = Aw'(2);
    localparam logic [Aw-1:0] ADDR_ESEL = Aw'(3);

    logic [PORT_WIDTH-1:0] sync1, sync2;
    logic [PORT_WIDTH-1:0] deb, deb_q;
    logic [PS_W-1:0]       ps_cnt;
    logic                  tick;
    logic [CNT_W-1:0]      deb_cnt [PORT_WIDTH];
    logic [PORT_WIDTH-1:0] rise, fall, ev;
    logic [PORT_WIDTH-1:0] edge_r, edge_sel, edge_clr;
    logic                  access, wr_en;
    logic [Dw-1:0]         rd_data;
    logic                  unused;

    assign sa_err_o = 1'b0;
    assign sa_rty_o = 1'b0;
    // Byte selects are ignored (full-word access only); upper data bits have no storage.
    assign unused   = ^{sa_sel_i, sa_dat_i};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_port_i;
            sync2 <= sync1;
        end
    end

    assign tick = (ps_cnt == PS_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    // A bit flips only after DEB_TICKS consecutive ticks of disagreement.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb <= '0;
            for (int i = 0; i < PORT_WIDTH; i++) begin
                deb_cnt[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < PORT_WIDTH; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q <= '0;
        end else begin
            deb_q <= deb;
        end
    end

    assign rise = deb & ~deb_q;
    assign fall = ~deb & deb_q;
    assign ev   = (edge_sel & rise) | (~edge_sel & fall);

    assign access   = sa_stb_i & sa_cyc_i & ~sa_ack_o;
    assign wr_en    = access & sa_we_i;
    assign edge_clr = (wr_en && sa_addr_i == ADDR_EDGE) ? sa_dat_i[PORT_WIDTH-1:0] : '0;

    // New events are OR-ed in after the clear so a coincident event is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_r   <= '0;
            edge_sel <= '1;
        end else begin
            edge_r <= (edge_r & ~edge_clr) | ev;
            if (wr_en && sa_addr_i == ADDR_ESEL) begin
                edge_sel <= sa_dat_i[PORT_WIDTH-1:0];
            end
        end
    end

`ifdef BTN_IRQ_EN
    logic [PORT_WIDTH-1:0] mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= '0;
            irq  <= 1'b0;
        end else begin
            if (wr_en && sa_addr_i == ADDR_MASK) begin
                mask <= sa_dat_i[PORT_WIDTH-1:0];
            end
            irq <= |(edge_r & mask);
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        case (sa_addr_i)
            ADDR_DATA: rd_data[PORT_WIDTH-1:0] = deb;
            ADDR_EDGE: rd_data[PORT_WIDTH-1:0] = edge_r;
`ifdef BTN_IRQ_EN
            ADDR_MASK: rd_data[PORT_WIDTH-1:0] = mask;
`endif
            ADDR_ESEL: rd_data[PORT_WIDTH-1:0] = edge_sel;
            default:   rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sa_ack_o <= 1'b0;
            sa_dat_o <= '0;
        end else begin
            sa_ack_o <= access;
            sa_dat_o <= access ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_button_in_wb.sv
// Bench for button_in_wb (PORT_WIDTH=4, PRESCALE=4, DEB_TICKS=3); irq checks only when BTN_IRQ_EN is defined.
module tb_button_in_wb;

    localparam int PW       = 4;
    localparam int PRESCALE = 4;
    localparam int DEB      = 3;

`ifdef BTN_IRQ_EN
    localparam logic [31:0] MASK_RB = 32'hA;
`else
    localparam logic [31:0] MASK_RB = 32'h0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] btn_port_i;
    logic [31:0]   sa_dat_i;
    logic [3:0]    sa_sel_i;
    logic [1:0]    sa_addr_i;
    logic          sa_stb_i, sa_cyc_i, sa_we_i;
    logic [31:0]   sa_dat_o;
    logic          sa_ack_o, sa_err_o, sa_rty_o;
`ifdef BTN_IRQ_EN
    logic          irq;
`endif

    button_in_wb #(
        .PORT_WIDTH(PW), .Dw(32), .Aw(2), .PRESCALE(PRESCALE), .DEB_TICKS(DEB)
    ) dut (
        .clk(clk), .reset(reset), .btn_port_i(btn_port_i),
        .sa_dat_i(sa_dat_i), .sa_sel_i(sa_sel_i), .sa_addr_i(sa_addr_i),
        .sa_stb_i(sa_stb_i), .sa_cyc_i(sa_cyc_i), .sa_we_i(sa_we_i),
        .sa_dat_o(sa_dat_o), .sa_ack_o(sa_ack_o), .sa_err_o(sa_err_o), .sa_rty_o(sa_rty_o)
`ifdef BTN_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [31:0] exp;
        string       name;
    } sb_item_t;

    typedef struct {
        bit          we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    sb_item_t sb_q[$];
    sb_item_t mon_it;
    vec_t     vecs[16];
    int       checks = 0;
    int       failures = 0;
    int       ecount = 0;

    // Non-reset clock edges since the last reset edge; a debounce tick lands where ecount % PRESCALE == 0.
    always @(posedge clk) begin
        if (reset) ecount <= 0;
        else       ecount <= ecount + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sa_ack_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=ack expected=no_ack t=%0t", $time);
            end else begin
                mon_it = sb_q.pop_front();
                if (mon_it.rd) check(mon_it.name, sa_dat_o, mon_it.exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input bit we, input logic [1:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input string nm);
        sb_item_t it;
        it.rd = !we; it.exp = exp; it.name = nm;
        sb_q.push_back(it);
        sa_stb_i = 1'b1; sa_cyc_i = 1'b1; sa_we_i = we; sa_addr_i = a; sa_dat_i = d;
        tick(1);
        check({nm, "_ack"}, {31'b0, sa_ack_o}, 32'd1);
        sa_stb_i = 1'b0; sa_cyc_i = 1'b0; sa_we_i = 1'b0;
        tick(1);
        check({nm, "_ack_drop"}, {31'b0, sa_ack_o}, 32'd0);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
        bus(1'b0, a, 32'h0, exp, nm);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input string nm);
        bus(1'b1, a, d, 32'h0, nm);
    endtask

    task automatic align_tick();
        for (int i = 0; i <= PRESCALE; i++) begin
            if (ecount != 0 && (ecount % PRESCALE) == 0) break;
            tick(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vecs[0]  = '{1'b0, 2'd0, 32'h0,         32'h0,   "rst_data"};
        vecs[1]  = '{1'b0, 2'd1, 32'h0,         32'h0,   "rst_edge"};
        vecs[2]  = '{1'b0, 2'd2, 32'h0,         32'h0,   "rst_mask"};
        vecs[3]  = '{1'b0, 2'd3, 32'h0,         32'hF,   "rst_esel"};
        vecs[4]  = '{1'b1, 2'd3, 32'h5,         32'h0,   "wr_esel5"};
        vecs[5]  = '{1'b0, 2'd3, 32'h0,         32'h5,   "rd_esel5"};
        vecs[6]  = '{1'b1, 2'd0, 32'hF,         32'h0,   "wr_data_ro"};
        vecs[7]  = '{1'b0, 2'd0, 32'h0,         32'h0,   "rd_data_ro"};
        vecs[8]  = '{1'b1, 2'd2, 32'hA,         32'h0,   "wr_maskA"};
        vecs[9]  = '{1'b0, 2'd2, 32'h0,         MASK_RB, "rd_maskA"};
        vecs[10] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0,   "wr_esel_all"};
        vecs[11] = '{1'b0, 2'd3, 32'h0,         32'hF,   "rd_esel_trunc"};
        vecs[12] = '{1'b1, 2'd2, 32'h0,         32'h0,   "wr_mask0"};
        vecs[13] = '{1'b0, 2'd2, 32'h0,         32'h0,   "rd_mask0"};
        vecs[14] = '{1'b1, 2'd1, 32'hF,         32'h0,   "wr_edge_w1c"};
        vecs[15] = '{1'b0, 2'd1, 32'h0,         32'h0,   "rd_edge0"};

        reset = 1'b1; btn_port_i = '0; sa_dat_i = '0; sa_sel_i = 4'hF; sa_addr_i = '0;
        sa_stb_i = 1'b0; sa_cyc_i = 1'b0; sa_we_i = 1'b0;
        tick(3);
        reset = 1'b0;
        check("rst_ack", {31'b0, sa_ack_o}, 32'd0);
        check("rst_dat", sa_dat_o, 32'h0);
        check("err_rty", {30'b0, sa_err_o, sa_rty_o}, 32'd0);
`ifdef BTN_IRQ_EN
        check("rst_irq", {31'b0, irq}, 32'd0);
`endif

        for (int i = 0; i < 16; i++) begin
            bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].name);
        end

        // Strobe without cyc must not be acked.
        sa_stb_i = 1'b1; sa_addr_i = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("stb_no_cyc", {31'b0, sa_ack_o}, 32'd0);
        end
        // Held strobe: ack, forced idle, ack.
        sb_q.push_back('{1'b1, 32'hF, "b2b_rd0"});
        sb_q.push_back('{1'b1, 32'hF, "b2b_rd1"});
        sa_cyc_i = 1'b1;
        tick(1); check("b2b_ack0", {31'b0, sa_ack_o}, 32'd1);
        tick(1); check("b2b_idle", {31'b0, sa_ack_o}, 32'd0);
        tick(1); check("b2b_ack1", {31'b0, sa_ack_o}, 32'd1);
        sa_stb_i = 1'b0; sa_cyc_i = 1'b0;
        tick(1); check("b2b_drop", {31'b0, sa_ack_o}, 32'd0);

        // Stable press of bit0: accepted between 11 and 14 edges after the change.
        btn_port_i = 4'b0001;
        tick(10);
        rd(2'd0, 32'h0, "press_early");
        tick(2);
        rd(2'd0, 32'h1, "press_accepted");
        rd(2'd1, 32'h1, "press_edge");
`ifdef BTN_IRQ_EN
        check("irq_masked", {31'b0, irq}, 32'd0);
`endif
        wr(2'd1, 32'h1, "w1c_press");
        rd(2'd1, 32'h0, "w1c_press_rd");

        // 6-cycle glitch on bit1 is rejected.
        btn_port_i = 4'b0011;
        tick(6);
        btn_port_i = 4'b0001;
        tick(20);
        rd(2'd0, 32'h1, "glitch_data");
        rd(2'd1, 32'h0, "glitch_edge");

        // Falling-edge capture with interrupt.
        wr(2'd2, 32'h1, "mask1");
        wr(2'd3, 32'h0, "esel_fall");
        rd(2'd3, 32'h0, "esel_fall_rd");
        btn_port_i = 4'b0000;
`ifdef BTN_IRQ_EN
        check("irq_pre_fall", {31'b0, irq}, 32'd0);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            if (irq === 1'b1) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat < 13 || lat > 16) begin
            failures++;
            $display("FAIL irq_latency actual=%0d expected=13..16", lat);
        end
`else
        lat = 0;
        tick(20);
`endif
        rd(2'd1, 32'h1, "fall_edge");
        rd(2'd0, 32'h0, "fall_data");
`ifdef BTN_IRQ_EN
        check("irq_held", {31'b0, irq}, 32'd1);
`endif
        wr(2'd1, 32'h1, "w1c_fall");
`ifdef BTN_IRQ_EN
        check("irq_cleared", {31'b0, irq}, 32'd0);
`endif
        rd(2'd1, 32'h0, "w1c_fall_rd");

        // Edge event lands on the same edge as a W1C of that bit: set wins.
        wr(2'd3, 32'hF, "esel_rise");
        align_tick();
        btn_port_i = 4'b0001;
        tick(12);
        wr(2'd1, 32'h1, "w1c_collide");
        rd(2'd1, 32'h1, "collide_edge");
        rd(2'd0, 32'h1, "collide_data");
        wr(2'd1, 32'h1, "w1c_after");
        rd(2'd1, 32'h0, "w1c_after_rd");

        // Reset mid-access with bit1 debounce two ticks in.
        align_tick();
        btn_port_i = 4'b0011;
        tick(8);
        sb_q.push_back('{1'b1, 32'h1, "midrst_rd"});
        sa_stb_i = 1'b1; sa_cyc_i = 1'b1; sa_we_i = 1'b0; sa_addr_i = 2'd0;
        tick(1);
        check("midrst_ack", {31'b0, sa_ack_o}, 32'd1);
        reset = 1'b1;
        tick(1);
        check("midrst_ack_drop", {31'b0, sa_ack_o}, 32'd0);
        reset = 1'b0; sa_stb_i = 1'b0; sa_cyc_i = 1'b0;
        rd(2'd0, 32'h0, "post_rst_data");
        rd(2'd1, 32'h0, "post_rst_edge");
        rd(2'd2, 32'h0, "post_rst_mask");
        rd(2'd3, 32'hF, "post_rst_esel");
`ifdef BTN_IRQ_EN
        check("post_rst_irq", {31'b0, irq}, 32'd0);
`endif
        tick(3);
        rd(2'd0, 32'h0, "reaccept_early");
        rd(2'd0, 32'h3, "reaccept_data");
        rd(2'd1, 32'h3, "reaccept_edge");

        tick(2);
        check("sb_drain", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_in_wb.md
Name: button_in_wb

Overview:
- Wishbone slave input peripheral: the input counterpart of the LED output port.
- Samples PORT_WIDTH external pushbutton or switch lines and passes each through a 2-flop synchronizer and a per-bit debouncer.
- Latches selected edges into a sticky capture register and optionally raises an interrupt to the CPU.
- Sits on the SoC Wishbone bus beside the LED/GPIO output peripheral.

Parameters:
- PORT_WIDTH, 1, number of button input lines (1..32).
- Dw, 32, Wishbone data width.
- Aw, 2, Wishbone word-address width. Four registers.
- PRESCALE, 50000, clk cycles per debounce sample tick (>=2).
- DEB_TICKS, 8, consecutive ticks an input must differ from the debounced value before it is accepted (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- btn_port_i  input  PORT_WIDTH  raw asynchronous button lines, active-high.
- sa_dat_i  input  Dw  write data.
- sa_sel_i  input  Dw/8  byte select. Ignored: full-word access only.
- sa_addr_i  input  Aw  word address.
- sa_stb_i  input  1  strobe.
- sa_cyc_i  input  1  cycle.
- sa_we_i  input  1  write enable.
- sa_dat_o  output  Dw  read data.
- sa_ack_o  output  1  acknowledge.
- sa_err_o  output  1  error, tied 0.
- sa_rty_o  output  1  retry, tied 0.
- irq  output  1  level interrupt (present only with BTN_IRQ_EN).

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high, on the reset port.
- Reset values: sa_ack_o=0, sa_dat_o=0, irq=0, synchronizer flops=0, debounced=0, EDGE=0, MASK=0, EDGE_SEL=all 1s, prescaler=0, all debounce counters=0.
- Synchronizer: two flops per bit. The value sync is btn_port_i delayed 2 cycles.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick=1 for one cycle when count==PRESCALE-1.
- Debouncer, per bit, acting only on tick:
  - If sync==deb: cnt<=0.
  - Else if cnt==DEB_TICKS-1: deb<=sync and cnt<=0.
  - Else: cnt<=cnt+1.
  - A glitch shorter than DEB_TICKS ticks never changes deb.
  - Acceptance latency after a stable input change: 2 + (DEB_TICKS-1)*PRESCALE + 1..PRESCALE cycles.
- Edge detect: deb_q is deb delayed 1 cycle.
  - rise = deb & ~deb_q; fall = ~deb & deb_q.
  - ev[i] = EDGE_SEL[i] ? rise[i] : fall[i].
- Registers (word address; unused upper bits of sa_dat_o read 0):
  - 0 DATA: RO, debounced value. Writes ignored but still acked.
  - 1 EDGE: sticky, set by ev. Writing 1 to a bit clears it (W1C). If ev and a clear hit the same bit in the same cycle, set wins.
  - 2 MASK: RW interrupt enable.
  - 3 EDGE_SEL: RW. 1=rising, 0=falling.
- Bus handshake:
  - sa_ack_o <= sa_stb_i & sa_cyc_i & ~sa_ack_o. This gives exactly one ack cycle per access, 1 cycle after the strobe, with a forced idle cycle between back-to-back accesses.
  - Write side effects occur on the cycle sa_ack_o is asserted (registered with the ack).
  - sa_dat_o is registered and valid while sa_ack_o=1.
  - A strobe without cyc is ignored.
- Reset mid-access: ack drops the next cycle and the access is lost. Reset also clears any partial debounce count.
- irq <= |(EDGE & MASK), registered, 1 cycle after EDGE or MASK changes. It stays high until software clears EDGE or MASK.

Optional Feature:
- Macro BTN_IRQ_EN.
- Defined: irq port and the MASK register exist as described above.
- Undefined:
  - No irq port.
  - Address 2 reads 0 and writes are ignored but acked.
  - EDGE still captures, so software polls it.

Test Plan:
All scenarios use PORT_WIDTH=4, PRESCALE=4, DEB_TICKS=3, BTN_IRQ_EN defined.
1. Reset, then read all four addresses -> DATA=0, EDGE=0, MASK=0, EDGE_SEL=0xF. Each access acks exactly once, 1 cycle after strobe.
2. btn_port_i=4'b0001 held stable -> DATA reads 0x1 within 2+8+4=14 cycles and never earlier than 11. EDGE bit0=1.
3. Pulse btn_port_i[1] high for 6 cycles (<3 ticks) -> DATA bit1 stays 0 and EDGE stays 0.
4. Write MASK=0x1, EDGE_SEL=0x0, release bit0 -> EDGE bit0 set on fall and irq=1 one cycle later. Write EDGE=0x1 -> EDGE=0 and irq=0 the following cycle.
5. Force a bit0 edge event in the same cycle as a W1C write of 0x1 to EDGE -> EDGE bit0 reads 1.
6. Assert reset during an active stb/cyc with a debounce in progress -> ack=0 next cycle and all registers at reset values. The held input is re-accepted only after a full debounce interval.
